// File: rtl/spi_fsm_pkg.sv
// Shared state encoding and default geometry for the SPI slave transaction controller.
package spi_fsm_pkg;

  localparam int ADDR_BITS_DEF = 7;
  localparam int DATA_BITS_DEF = 8;
  localparam int CNT_W_DEF     = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GET_ADDR   = 3'd1,
    GOT_ADDR   = 3'd2,
    READ_LOAD  = 3'd3,
    READ_SEND  = 3'd4,
    WRITE_RECV = 3'd5,
    WRITE_MEM  = 3'd6,
    DONE       = 3'd7
  } state_e;

endpackage

// File: rtl/spi_fsm_bit_counter.sv
// Saturating bit counter with synchronous clear; last_o flags that one more
// increment reaches the terminal count.
module spi_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == (term_i - CNT_W'(1)));

endmodule

// File: rtl/spi_fsm.sv
// SPI slave transaction controller: address/RW phase followed by one read or
// write data phase, with Moore enables registered alongside the state.
module spi_fsm
  import spi_fsm_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cs_n,
  input  logic sclk_posedge,
  input  logic sclk_negedge,
  input  logic rw_bit,
  output logic sr_we,
  output logic addr_we,
  output logic dm_we,
  output logic miso_buff,
  output logic busy
);

  localparam logic [CNT_W-1:0] ADDR_TERM = CNT_W'(ADDR_BITS + 1);
  localparam logic [CNT_W-1:0] DATA_TERM = CNT_W'(DATA_BITS);

  state_e           state_q, state_d;
  logic             cnt_last;
  logic             cnt_inc;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_term;

  always_comb begin
    cnt_term = (state_q == GET_ADDR) ? ADDR_TERM : DATA_TERM;
    cnt_inc  = 1'b0;
    case (state_q)
      GET_ADDR, WRITE_RECV: cnt_inc = sclk_posedge;
      READ_SEND:            cnt_inc = sclk_negedge;
      default:              cnt_inc = 1'b0;
    endcase
    // Every state change starts a fresh phase, including aborts.
    cnt_clr = (state_d != state_q);
  end

  spi_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .term_i  (cnt_term),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (!cs_n) state_d = GET_ADDR;
      GET_ADDR:   if (cs_n) state_d = IDLE;
                  else if (sclk_posedge && cnt_last) state_d = GOT_ADDR;
      GOT_ADDR:   if (cs_n) state_d = IDLE;
                  else state_d = rw_bit ? READ_LOAD : WRITE_RECV;
      READ_LOAD:  state_d = cs_n ? IDLE : READ_SEND;
      READ_SEND:  if (cs_n) state_d = IDLE;
                  else if (sclk_negedge && cnt_last) state_d = DONE;
      WRITE_RECV: if (cs_n) state_d = IDLE;
                  else if (sclk_posedge && cnt_last) state_d = WRITE_MEM;
      WRITE_MEM:  state_d = cs_n ? IDLE : DONE;
      DONE:       if (cs_n) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_we   <= 1'b0;
      sr_we     <= 1'b0;
      dm_we     <= 1'b0;
      miso_buff <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_we   <= (state_d == GOT_ADDR);
      sr_we     <= (state_d == READ_LOAD);
      dm_we     <= (state_d == WRITE_MEM);
      miso_buff <= (state_d == READ_SEND);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm: transaction table, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_spi_fsm;

  localparam int A = 7;
  localparam int D = 8;

  logic clk;
  logic reset_n;
  logic cs_n;
  logic sclk_posedge;
  logic sclk_negedge;
  logic rw_bit;
  logic sr_we;
  logic addr_we;
  logic dm_we;
  logic miso_buff;
  logic busy;

  spi_fsm dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cs_n         (cs_n),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .rw_bit       (rw_bit),
    .sr_we        (sr_we),
    .addr_we      (addr_we),
    .dm_we        (dm_we),
    .miso_buff    (miso_buff),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int c_addr, c_sr, c_dm, c_mwin;
  bit prev_miso;
  bit chk_model;

  // Transaction-level reference: rises/falls seen, cycles since the address
  // completed, and whether we are finished and waiting for cs_n to rise.
  bit m_txn, m_mem, m_fin, m_read;
  int m_rises, m_falls, m_since;

  typedef struct {
    bit    rw;
    int    ncyc;
    int    addr;
    int    sr;
    int    dm;
    int    mwin;
    bit    busy_end;
    bit    miso_end;
    string name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_txn = 0; m_mem = 0; m_fin = 0; m_read = 0;
    m_rises = 0; m_falls = 0; m_since = -1;
  endtask

  task automatic model_step(input bit cs, input bit p, input bit n, input bit rw);
    if (m_mem) begin
      m_mem = 0;
      m_fin = !cs;
    end else if (m_fin) begin
      if (cs) m_fin = 0;
    end else if (!m_txn) begin
      if (!cs) begin
        m_txn = 1; m_rises = 0; m_falls = 0; m_since = -1; m_read = 0;
      end
    end else if (cs) begin
      m_txn = 0;
    end else if (m_since < 0) begin
      if (p) begin
        m_rises++;
        if (m_rises == A + 1) m_since = 0;
      end
    end else if (m_since == 0) begin
      m_read  = rw;
      m_since = 1;
    end else if (m_read) begin
      if (m_since == 1) begin
        m_since = 2;
      end else if (n) begin
        m_falls++;
        if (m_falls == D) begin
          m_txn = 0;
          m_fin = 1;
        end
      end
    end else if (p) begin
      m_rises++;
      if (m_rises == A + 1 + D) begin
        m_txn = 0;
        m_mem = 1;
      end
    end
  endtask

  task automatic cyc();
    bit cs, p, n, rw;
    cs = cs_n; p = sclk_posedge; n = sclk_negedge; rw = rw_bit;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step(cs, p, n, rw);
    #1;
    if (addr_we) c_addr++;
    if (sr_we) c_sr++;
    if (dm_we) c_dm++;
    if (miso_buff && !prev_miso) c_mwin++;
    prev_miso = miso_buff;
    if (chk_model) begin
      check("rnd addr_we", int'(addr_we), int'(m_txn && m_since == 0));
      check("rnd sr_we", int'(sr_we), int'(m_txn && m_read && m_since == 1));
      check("rnd miso_buff", int'(miso_buff), int'(m_txn && m_read && m_since >= 2));
      check("rnd dm_we", int'(dm_we), int'(m_mem));
      check("rnd busy", int'(busy), int'(m_txn || m_mem || m_fin));
    end
  endtask

  task automatic sclk_rise();
    sclk_posedge = 1'b1;
    cyc();
    sclk_posedge = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic sclk_fall();
    sclk_negedge = 1'b1;
    cyc();
    sclk_negedge = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic clear_counts();
    c_addr = 0; c_sr = 0; c_dm = 0; c_mwin = 0;
  endtask

  task automatic run_txn(input vec_t v);
    clear_counts();
    rw_bit = v.rw;
    cs_n   = 1'b0;
    cyc();
    for (int i = 0; i < v.ncyc; i++) begin
      sclk_rise();
      sclk_fall();
    end
    check({v.name, " busy_end"}, int'(busy), int'(v.busy_end));
    check({v.name, " miso_end"}, int'(miso_buff), int'(v.miso_end));
    cs_n = 1'b1;
    repeat (2) cyc();
    check({v.name, " addr_we pulses"}, c_addr, v.addr);
    check({v.name, " sr_we pulses"}, c_sr, v.sr);
    check({v.name, " dm_we pulses"}, c_dm, v.dm);
    check({v.name, " miso windows"}, c_mwin, v.mwin);
    check({v.name, " busy_after"}, int'(busy), 0);
    $display("txn %s rw=%0d sclk_cycles=%0d addr=%0d sr=%0d dm=%0d miso_win=%0d",
             v.name, v.rw, v.ncyc, c_addr, c_sr, c_dm, c_mwin);
  endtask

  initial begin
    vecs[0] = '{0, 16, 1, 0, 1, 0, 1, 0, "write"};
    vecs[1] = '{1, 16, 1, 1, 0, 1, 1, 0, "read"};
    vecs[2] = '{0, 13, 1, 0, 0, 0, 1, 0, "write_abort"};
    vecs[3] = '{0, 16, 1, 0, 1, 0, 1, 0, "write_after_abort"};
    vecs[4] = '{1, 10, 1, 1, 0, 1, 1, 1, "read_abort"};
    vecs[5] = '{0, 3,  0, 0, 0, 0, 1, 0, "addr_abort"};
    vecs[6] = '{0, 20, 1, 0, 1, 0, 1, 0, "write_extra"};
    vecs[7] = '{1, 20, 1, 1, 0, 1, 1, 0, "read_extra"};

    chk_model    = 0;
    prev_miso    = 0;
    reset_n      = 1'b0;
    cs_n         = 1'b1;
    sclk_posedge = 1'b0;
    sclk_negedge = 1'b0;
    rw_bit       = 1'b0;
    model_reset();
    clear_counts();
    repeat (3) cyc();
    check("reset addr_we", int'(addr_we), 0);
    check("reset sr_we", int'(sr_we), 0);
    check("reset dm_we", int'(dm_we), 0);
    check("reset miso_buff", int'(miso_buff), 0);
    check("reset busy", int'(busy), 0);
    reset_n = 1'b1;
    repeat (2) cyc();
    check("idle busy", int'(busy), 0);

    // Reset asserted mid address phase must clear outputs without a clock edge.
    cs_n = 1'b0;
    cyc();
    repeat (3) begin
      sclk_rise();
      sclk_fall();
    end
    check("mid_addr busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst busy", int'(busy), 0);
    check("async_rst addr_we", int'(addr_we), 0);
    check("async_rst sr_we", int'(sr_we), 0);
    check("async_rst dm_we", int'(dm_we), 0);
    check("async_rst miso_buff", int'(miso_buff), 0);
    cs_n = 1'b1;
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    check("post_rst idle busy", int'(busy), 0);
    $display("seq async_reset done");

    foreach (vecs[i]) run_txn(vecs[i]);

    // Stray edges with cs_n high, then exact enable latencies.
    clear_counts();
    cs_n = 1'b1;
    repeat (3) begin
      sclk_rise();
      sclk_fall();
    end
    check("stray busy", int'(busy), 0);
    check("stray addr_we pulses", c_addr, 0);
    cs_n   = 1'b0;
    rw_bit = 1'b0;
    cyc();
    for (int i = 1; i <= A + 1 + D; i++) begin
      sclk_posedge = 1'b1;
      cyc();
      sclk_posedge = 1'b0;
      if (i == A)         check("lat addr_we before", int'(addr_we), 0);
      if (i == A + 1)     check("lat addr_we after rise", int'(addr_we), 1);
      if (i == A + D)     check("lat dm_we before", int'(dm_we), 0);
      if (i == A + 1 + D) check("lat dm_we after rise", int'(dm_we), 1);
      cyc();
      if (i == A + 1) begin
        check("lat addr_we one clk", int'(addr_we), 0);
        check("lat sr_we write", int'(sr_we), 0);
      end
      if (i == A + 1 + D) begin
        check("lat dm_we one clk", int'(dm_we), 0);
        check("lat done busy", int'(busy), 1);
      end
      repeat (2) cyc();
      sclk_fall();
    end
    cs_n = 1'b1;
    repeat (2) cyc();
    check("lat idle busy", int'(busy), 0);
    $display("seq stray_and_latency addr=%0d dm=%0d", c_addr, c_dm);

    // Randomized run against the transaction model.
    begin
      bit lvl;
      int half_cnt;
      lvl = 0;
      half_cnt = 3;
      cs_n = 1'b1;
      repeat (4) cyc();
      model_reset();
      clear_counts();
      chk_model = 1;
      for (int k = 0; k < 3000; k++) begin
        if (half_cnt == 0) begin
          lvl = ~lvl;
          sclk_posedge = lvl;
          sclk_negedge = !lvl;
          half_cnt = int'($urandom_range(3, 6));
        end else begin
          sclk_posedge = 1'b0;
          sclk_negedge = 1'b0;
          half_cnt--;
        end
        if (cs_n) begin
          if ($urandom_range(0, 29) == 0) cs_n = 1'b0;
        end else if ($urandom_range(0, 399) == 0) begin
          cs_n = 1'b1;
        end
        rw_bit = ($urandom_range(0, 1) == 1);
        cyc();
      end
      chk_model = 0;
      $display("random run addr=%0d sr=%0d dm=%0d miso_win=%0d", c_addr, c_sr, c_dm, c_mwin);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
